// File: rtl/demux_seq_pkg.sv
// Shared types and default sizing for the demux write sequencer.
// Encodings are fixed so the state can be observed in traces by value.
package demux_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DATA_W_DEFAULT     = 5;
    localparam int SEL_W_DEFAULT      = 5;
    localparam int NUM_CH_DEFAULT     = 30;
    localparam int NUM_GROUPS_DEFAULT = 16;
    localparam int GRP_W_DEFAULT      = 4;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MOD up-counter with synchronous clear; wrap flags the increment that rolls over.
// Clear wins over increment.
module wrap_counter #(
    parameter int MOD = 30,
    parameter int W   = 5
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign wrap = inc && (count == LAST);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= (count == LAST) ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/demux_30_write_sequencer.sv
// Round-robin write sequencer feeding a 1-to-NUM_CH demux: one registered strobe per accepted word.
// Accept-to-strobe latency is one cycle; din_ready is high only while a job is running.
module demux_30_write_sequencer
    import demux_seq_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int SEL_W      = SEL_W_DEFAULT,
    parameter int NUM_CH     = NUM_CH_DEFAULT,
    parameter int NUM_GROUPS = NUM_GROUPS_DEFAULT,
    parameter int GRP_W      = GRP_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DATA_W-1:0] dout,
    output logic [SEL_W-1:0]  sel,
    output logic              wr_en,
    output logic [GRP_W-1:0]  grp_idx,
    output logic              busy,
    output logic              done
);

    state_t             state;
    state_t             next_state;
    logic               accept;
    logic               final_word;
    logic               cnt_clr;
    logic               ch_wrap;
    logic [SEL_W-1:0]   ch_cnt;
    logic [GRP_W-1:0]   grp_cnt;

    assign accept  = din_valid && din_ready;
    assign cnt_clr = reset || ((state == IDLE) && start) || (state == DONE);

    wrap_counter #(
        .MOD (NUM_CH),
        .W   (SEL_W)
    ) u_ch_cnt (
        .clk   (clk),
        .clr   (cnt_clr),
        .inc   (accept),
        .count (ch_cnt),
        .wrap  (ch_wrap)
    );

    // The group counter only wraps on the very last word of the job.
    wrap_counter #(
        .MOD (NUM_GROUPS),
        .W   (GRP_W)
    ) u_grp_cnt (
        .clk   (clk),
        .clr   (cnt_clr),
        .inc   (ch_wrap),
        .count (grp_cnt),
        .wrap  (final_word)
    );

    // The counter has already rolled to 0 by DONE; report the group just finished.
    assign grp_idx = (state == DONE) ? GRP_W'(NUM_GROUPS - 1) : grp_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (final_word) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        din_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            RUN: begin
                din_ready = 1'b1;
                busy      = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout  <= '0;
            sel   <= '0;
            wr_en <= 1'b0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                dout <= din;
                sel  <= ch_cnt;
            end
        end
    end

endmodule

// File: tb/tb_demux_30_write_sequencer.sv
// Scoreboard bench: lane 0 runs the 30x16 default build, lane 1 a 3x2 build.
module tb_demux_30_write_sequencer;

    typedef struct {
        logic [4:0] dout;
        logic [4:0] sel;
        bit         fin;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset     [2];
    logic       start     [2];
    logic [4:0] din       [2];
    logic       din_valid [2];
    logic       din_ready [2];
    logic [4:0] dout      [2];
    logic [4:0] sel       [2];
    logic       wr_en     [2];
    logic [3:0] grp_idx   [2];
    logic       busy      [2];
    logic       done      [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int NC  = (g == 0) ? 30 : 3;
        localparam int NG  = (g == 0) ? 16 : 2;
        localparam int TOT = NC * NG;

        demux_30_write_sequencer #(
            .DATA_W     (5),
            .SEL_W      (5),
            .NUM_CH     (NC),
            .NUM_GROUPS (NG),
            .GRP_W      (4)
        ) dut (
            .clk       (clk),
            .reset     (reset[g]),
            .start     (start[g]),
            .din       (din[g]),
            .din_valid (din_valid[g]),
            .din_ready (din_ready[g]),
            .dout      (dout[g]),
            .sel       (sel[g]),
            .wr_en     (wr_en[g]),
            .grp_idx   (grp_idx[g]),
            .busy      (busy[g]),
            .done      (done[g])
        );

        // Reference: a job is TOT words; word n goes to channel n%NC of group n/NC.
        exp_t       q[$];
        int         n       = 0;
        bit         run_m   = 0;
        bit         done_m  = 0;
        logic [4:0] last_d  = '0;
        logic [4:0] last_s  = '0;
        int         strobes = 0;

        always @(posedge clk) begin
            if (reset[g]) begin
                run_m = 0; done_m = 0; n = 0;
                last_d = '0; last_s = '0;
                q.delete();
            end else if (done_m) begin
                done_m = 0;
            end else if (!run_m) begin
                if (start[g]) begin
                    run_m = 1;
                    n = 0;
                end
            end else if (din_valid[g]) begin
                last_d = din[g];
                last_s = 5'(n % NC);
                q.push_back('{last_d, last_s, (n == TOT - 1)});
                n++;
                if (n == TOT) begin
                    run_m  = 0;
                    done_m = 1;
                end
            end
        end

        always @(negedge clk) begin
            exp_t e;
            chk($sformatf("lane%0d din_ready", g), int'(din_ready[g]), int'(run_m));
            chk($sformatf("lane%0d busy", g), int'(busy[g]), int'(run_m | done_m));
            chk($sformatf("lane%0d done", g), int'(done[g]), int'(done_m));
            chk($sformatf("lane%0d grp_idx", g), int'(grp_idx[g]),
                run_m ? n / NC : (done_m ? NG - 1 : 0));
            if (wr_en[g]) begin
                strobes++;
                if (q.size() == 0) begin
                    chk($sformatf("lane%0d spurious wr_en", g), 1, 0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("lane%0d dout", g), int'(dout[g]), int'(e.dout));
                    chk($sformatf("lane%0d sel", g), int'(sel[g]), int'(e.sel));
                    chk($sformatf("lane%0d final strobe", g), int'(done[g]), int'(e.fin));
                end
            end else begin
                chk($sformatf("lane%0d missing wr_en", g), q.size(), 0);
                chk($sformatf("lane%0d dout hold", g), int'(dout[g]), int'(last_d));
                chk($sformatf("lane%0d sel hold", g), int'(sel[g]), int'(last_s));
            end
        end
    end

    task automatic pulse_start(input int g);
        start[g] = 1'b1;
        tick();
        start[g] = 1'b0;
    endtask

    // mode 0: continuous, din = word index % 32; mode 1: valid pattern 1,0,0,1; mode 2: random.
    task automatic feed(input int g, input int cnt, input int mode, input int start_at);
        int acc = 0;
        int cyc = 0;
        bit v;
        while (acc < cnt && cyc < 5000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: v = ($urandom_range(9) < 7);
            endcase
            din[g]       = (mode == 0) ? 5'(acc % 32) : 5'($urandom);
            din_valid[g] = v;
            start[g]     = v && (acc == start_at);
            if (v && din_ready[g]) acc++;
            cyc++;
            tick();
        end
        start[g]     = 1'b0;
        din_valid[g] = 1'b0;
        if (acc < cnt) chk($sformatf("lane%0d feed timeout", g), acc, cnt);
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            reset[g] = 1'b1; start[g] = 1'b0; din_valid[g] = 1'b0; din[g] = '0;
        end
        repeat (3) tick();
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        tick();

        // Abort a job with reset, then restart it.
        pulse_start(0);
        feed(0, 7, 0, -1);
        reset[0] = 1'b1;
        tick();
        reset[0] = 1'b0;
        repeat (2) tick();

        // Full job: first sweep continuous, gapped run with a stray start at word 45, random rest.
        pulse_start(0);
        feed(0, 30, 0, -1);
        feed(0, 40, 1, 15);
        feed(0, 410, 2, -1);
        start[0] = 1'b1;
        din_valid[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (3) tick();
        din_valid[0] = 1'b0;
        tick();

        // Small build: back-to-back jobs with start in the cycle after done.
        pulse_start(1);
        feed(1, 6, 0, -1);
        tick();
        pulse_start(1);
        feed(1, 6, 2, -1);
        repeat (3) tick();

        chk("lane0 strobe count", lane[0].strobes, 7 + 480);
        chk("lane1 strobe count", lane[1].strobes, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
